// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP transmit path.
package udp_pkg;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    SEND      = 2'd1,
    GAP       = 2'd2,
    RETRY_GAP = 2'd3
  } udp_state_e;

  localparam int UDP_LENGTH_DEF = 960;
  localparam int MIN_GAP_DEF    = 16;

  // MSB bit index of payload byte slot idx; byte 0 occupies the top of the vector.
  function automatic int byte_msb(input int idx, input int nbytes);
    return nbytes * 8 - 1 - idx * 8;
  endfunction

endpackage

// File: rtl/udp_tx_timer.sv
// Loadable down-counter that flags expiry when it sits at zero; used for idle, ack and gap timing.
module udp_tx_timer #(
  parameter int W = 8
) (
  input  logic         clk_200m,
  input  logic         rstn,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority; decrementing stops at zero so expiry is sticky until reloaded.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_200m) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/udp_tx_packer.sv
// Packs a byte stream MSB-first into a parallel UDP payload and holds it until the
// Ethernet top acknowledges it, retrying after an acknowledge timeout.
module udp_tx_packer
  import udp_pkg::*;
#(
  parameter int UDP_LENGTH    = UDP_LENGTH_DEF,
  parameter int FLUSH_TIMEOUT = 20000,
  parameter int ACK_TIMEOUT   = 2000000,
  parameter int MIN_GAP       = MIN_GAP_DEF
) (
  input  logic                    clk_200m,
  input  logic                    rstn,
  input  logic [7:0]              s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_last,
  output logic                    udp_send_data_valid,
  output logic [UDP_LENGTH*8-1:0] udp_send_data,
  output logic [15:0]             udp_send_data_length,
  input  logic                    udp_send_accepted,
  output logic [15:0]             frames_sent,
  output logic [15:0]             retries
);

  localparam int IW     = $clog2(UDP_LENGTH + 1);
  localparam int BW     = $clog2(UDP_LENGTH * 8);
  localparam int IDLE_W = $clog2(FLUSH_TIMEOUT + 1);
  localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int GAP_W  = $clog2(MIN_GAP + 1);

  udp_state_e              state_q;
  logic [IW-1:0]           wr_idx_q;
  logic [UDP_LENGTH*8-1:0] data_q;
  logic [15:0]             len_q;
  logic                    ready_q;
  logic                    valid_q;
  logic [15:0]             frames_q;
  logic [15:0]             retries_q;

  logic accept_s;
  logic idle_exp_s, ack_exp_s, gap_exp_s;
  logic idle_dec_s, ack_load_s, gap_load_s;

  assign accept_s   = s_valid && ready_q;
  assign idle_dec_s = (state_q == FILL) && !accept_s && (wr_idx_q != '0);
  assign ack_load_s = (state_q != SEND);
  assign gap_load_s = (state_q != GAP) && (state_q != RETRY_GAP);

  udp_tx_timer #(.W(IDLE_W)) u_idle_timer (
    .clk_200m   (clk_200m),
    .rstn       (rstn),
    .load_i     (accept_s),
    .load_val_i (IDLE_W'(FLUSH_TIMEOUT - 1)),
    .dec_i      (idle_dec_s),
    .expired_o  (idle_exp_s)
  );

  udp_tx_timer #(.W(ACK_W)) u_ack_timer (
    .clk_200m   (clk_200m),
    .rstn       (rstn),
    .load_i     (ack_load_s),
    .load_val_i (ACK_W'(ACK_TIMEOUT - 1)),
    .dec_i      (!ack_load_s),
    .expired_o  (ack_exp_s)
  );

  udp_tx_timer #(.W(GAP_W)) u_gap_timer (
    .clk_200m   (clk_200m),
    .rstn       (rstn),
    .load_i     (gap_load_s),
    .load_val_i (GAP_W'(MIN_GAP - 1)),
    .dec_i      (!gap_load_s),
    .expired_o  (gap_exp_s)
  );

  // Frame FSM; ready and valid move on the same edge as the state so no extra byte slips in.
  always_ff @(posedge clk_200m) begin
    if (!rstn) begin
      state_q   <= FILL;
      wr_idx_q  <= '0;
      data_q    <= '0;
      len_q     <= 16'd0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      frames_q  <= 16'd0;
      retries_q <= 16'd0;
    end else begin
      case (state_q)
        FILL: begin
          ready_q <= 1'b1;
          if (accept_s) begin
            data_q[BW'(byte_msb(int'(wr_idx_q), UDP_LENGTH)) -: 8] <= s_data;
            wr_idx_q <= wr_idx_q + IW'(1);
            if ((wr_idx_q == IW'(UDP_LENGTH - 1)) || s_last) begin
              len_q   <= 16'(wr_idx_q) + 16'd1;
              state_q <= SEND;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
            end
          end else if ((wr_idx_q != '0) && idle_exp_s) begin
            len_q   <= 16'(wr_idx_q);
            state_q <= SEND;
            ready_q <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        SEND: begin
          // An accept coinciding with the timeout wins over the retry.
          if (udp_send_accepted) begin
            valid_q  <= 1'b0;
            frames_q <= frames_q + 16'd1;
            state_q  <= GAP;
          end else if (ack_exp_s) begin
            valid_q   <= 1'b0;
            retries_q <= retries_q + 16'd1;
            state_q   <= RETRY_GAP;
          end
        end
        GAP: begin
          if (gap_exp_s) begin
            data_q   <= '0;
            wr_idx_q <= '0;
            len_q    <= 16'd0;
            ready_q  <= 1'b1;
            state_q  <= FILL;
          end
        end
        RETRY_GAP: begin
          if (gap_exp_s) begin
            valid_q <= 1'b1;
            state_q <= SEND;
          end
        end
        default: begin
          state_q <= FILL;
          valid_q <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready              = ready_q;
  assign udp_send_data_valid  = valid_q;
  assign udp_send_data        = data_q;
  assign udp_send_data_length = len_q;
  assign frames_sent          = frames_q;
  assign retries              = retries_q;

endmodule

// File: tb/tb_udp_tx_packer.sv
// Directed bench for udp_tx_packer: a cycle-timestamp model checked every cycle, plus literal spot checks.
module tb_udp_tx_packer;

  localparam int L  = 16;
  localparam int FT = 100;
  localparam int AT = 1000;
  localparam int MG = 4;
  localparam int DW = L * 8;

  logic          clk_200m = 1'b0;
  logic          rstn = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_last = 1'b0;
  logic          udp_send_data_valid;
  logic [DW-1:0] udp_send_data;
  logic [15:0]   udp_send_data_length;
  logic          udp_send_accepted = 1'b0;
  logic [15:0]   frames_sent;
  logic [15:0]   retries;

  udp_tx_packer #(
    .UDP_LENGTH    (L),
    .FLUSH_TIMEOUT (FT),
    .ACK_TIMEOUT   (AT),
    .MIN_GAP       (MG)
  ) dut (
    .clk_200m             (clk_200m),
    .rstn                 (rstn),
    .s_data               (s_data),
    .s_valid              (s_valid),
    .s_ready              (s_ready),
    .s_last               (s_last),
    .udp_send_data_valid  (udp_send_data_valid),
    .udp_send_data        (udp_send_data),
    .udp_send_data_length (udp_send_data_length),
    .udp_send_accepted    (udp_send_accepted),
    .frames_sent          (frames_sent),
    .retries              (retries)
  );

  always #5 clk_200m = ~clk_200m;

  int tests_run = 0;
  int tests_failed = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Model: phase 0 collecting, 1 offering, 2 inter-frame gap. Timing is derived from
  // absolute edge numbers: an offer repeats with period AT+MG, high for the first AT edges.
  int            n = 0;
  int            phase = 0;
  int            last_acc = 0;
  int            send_start = 0;
  int            gap_start = 0;
  int            prev_off;
  logic [7:0]    q[$];
  logic          m_ready = 1'b0;
  logic          m_valid = 1'b0;
  logic [15:0]   m_len = 16'd0;
  logic [15:0]   m_frames = 16'd0;
  logic [15:0]   m_retries = 16'd0;
  logic [DW-1:0] m_data = '0;

  initial begin
    forever begin
      @(posedge clk_200m);
      n++;
      if (!rstn) begin
        phase = 0;
        q.delete();
        m_ready = 1'b0;
        m_valid = 1'b0;
        m_len = 16'd0;
        m_frames = 16'd0;
        m_retries = 16'd0;
        m_data = '0;
      end else begin
        if (phase == 0) begin
          if (s_valid && m_ready) begin
            q.push_back(s_data);
            last_acc = n;
            if (q.size() == L || s_last) begin
              phase = 1;
              send_start = n;
              m_len = 16'(q.size());
            end
          end else if (q.size() > 0 && (n - last_acc) == FT) begin
            phase = 1;
            send_start = n;
            m_len = 16'(q.size());
          end
        end else if (phase == 1) begin
          prev_off = (n - 1 - send_start) % (AT + MG);
          if (udp_send_accepted && prev_off < AT) begin
            phase = 2;
            gap_start = n;
            m_frames++;
          end else if (((n - send_start) % (AT + MG)) == AT) begin
            m_retries++;
          end
        end else begin
          if ((n - gap_start) == MG) begin
            phase = 0;
            q.delete();
            m_len = 16'd0;
          end
        end
        m_ready = (phase == 0);
        m_valid = (phase == 1) && (((n - send_start) % (AT + MG)) < AT);
        m_data = '0;
        foreach (q[i]) m_data[DW-1-8*i -: 8] = q[i];
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk_200m);
      if (chk_en) begin
        chk("cyc_ready",   DW'(s_ready),              DW'(m_ready));
        chk("cyc_valid",   DW'(udp_send_data_valid),  DW'(m_valid));
        chk("cyc_data",    udp_send_data,             m_data);
        chk("cyc_len",     DW'(udp_send_data_length), DW'(m_len));
        chk("cyc_frames",  DW'(frames_sent),          DW'(m_frames));
        chk("cyc_retries", DW'(retries),              DW'(m_retries));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic put_byte(input logic [7:0] d, input logic l);
    int guard;
    guard = 0;
    s_data = d;
    s_last = l;
    s_valid = 1'b1;
    while (!s_ready && guard < 3000) begin
      @(negedge clk_200m);
      guard++;
    end
    chk("put_ready", DW'(s_ready), DW'(1'b1));
    @(negedge clk_200m);
    s_last = 1'b0;
  endtask

  task automatic pulse();
    udp_send_accepted = 1'b1;
    @(negedge clk_200m);
    udp_send_accepted = 1'b0;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!s_ready && cnt < 5000) begin
      @(negedge clk_200m);
      cnt++;
    end
    chk("wait_ready", DW'(s_ready), DW'(1'b1));
  endtask

  int cnt;
  int seen;
  int guard;

  initial begin
    repeat (3) @(negedge clk_200m);
    chk_en = 1'b1;
    chk("rst_valid", DW'(udp_send_data_valid), DW'(1'b0));
    chk("rst_data", udp_send_data, '0);
    chk("rst_ready", DW'(s_ready), DW'(1'b0));
    rstn = 1'b1;
    @(negedge clk_200m);
    chk("rst_ready_after", DW'(s_ready), DW'(1'b1));

    // Full frame of 16 bytes.
    for (int i = 0; i < L; i++) put_byte(8'(i), 1'b0);
    s_valid = 1'b0;
    chk("full_valid", DW'(udp_send_data_valid), DW'(1'b1));
    chk("full_data", udp_send_data, 128'h000102030405060708090A0B0C0D0E0F);
    chk("full_len", DW'(udp_send_data_length), DW'(16'd16));
    repeat (50) @(negedge clk_200m);
    pulse();
    chk("full_valid_drop", DW'(udp_send_data_valid), DW'(1'b0));
    chk("full_frames", DW'(frames_sent), DW'(16'd1));
    wait_ready(cnt);
    chk("gap_cycles", DW'(cnt), DW'(32'd4));

    // Short message ended by s_last.
    put_byte(8'hAA, 1'b0);
    put_byte(8'hBB, 1'b0);
    put_byte(8'hCC, 1'b1);
    s_valid = 1'b0;
    chk("last_valid", DW'(udp_send_data_valid), DW'(1'b1));
    chk("last_len", DW'(udp_send_data_length), DW'(16'd3));
    chk("last_data", udp_send_data, 128'hAABBCC00000000000000000000000000);
    pulse();
    wait_ready(cnt);

    // Idle flush after five bytes.
    for (int i = 1; i <= 5; i++) put_byte(8'(i), 1'b0);
    s_valid = 1'b0;
    repeat (99) @(negedge clk_200m);
    chk("idle_not_yet", DW'(udp_send_data_valid), DW'(1'b0));
    @(negedge clk_200m);
    chk("idle_valid", DW'(udp_send_data_valid), DW'(1'b1));
    chk("idle_len", DW'(udp_send_data_length), DW'(16'd5));
    chk("idle_data", udp_send_data, 128'h01020304050000000000000000000000);
    pulse();
    wait_ready(cnt);

    // Empty buffer must never time out.
    seen = 0;
    repeat (10000) begin
      @(negedge clk_200m);
      if (udp_send_data_valid) seen++;
    end
    chk("no_empty_frame", DW'(seen), DW'(32'd0));

    // Backpressure: the 17th byte is held across the frame boundary.
    for (int i = 0; i < L; i++) put_byte(8'h10 + 8'(i), 1'b0);
    s_data = 8'h20;
    s_last = 1'b1;
    s_valid = 1'b1;
    chk("bp_len", DW'(udp_send_data_length), DW'(16'd16));
    repeat (10) @(negedge clk_200m);
    chk("bp_ready_low", DW'(s_ready), DW'(1'b0));
    chk("bp_data", udp_send_data, 128'h101112131415161718191A1B1C1D1E1F);
    pulse();
    chk("bp_frames", DW'(frames_sent), DW'(16'd4));
    put_byte(8'h20, 1'b1);
    s_valid = 1'b0;
    chk("bp_next_len", DW'(udp_send_data_length), DW'(16'd1));
    chk("bp_next_data", udp_send_data, 128'h20000000000000000000000000000000);
    pulse();
    wait_ready(cnt);

    // Ack timeout with retries, accepted on the third offer.
    put_byte(8'h5A, 1'b0);
    put_byte(8'hA5, 1'b1);
    s_valid = 1'b0;
    cnt = 0;
    while (udp_send_data_valid && cnt < 2000) begin
      cnt++;
      @(negedge clk_200m);
    end
    chk("ack_hold", DW'(cnt), DW'(32'd1000));
    cnt = 0;
    while (!udp_send_data_valid && cnt < 100) begin
      cnt++;
      @(negedge clk_200m);
    end
    chk("retry_gap", DW'(cnt), DW'(32'd4));
    chk("retry_one", DW'(retries), DW'(16'd1));
    guard = 0;
    while (retries != 16'd2 && guard < 3000) begin
      @(negedge clk_200m);
      guard++;
    end
    guard = 0;
    while (!udp_send_data_valid && guard < 100) begin
      @(negedge clk_200m);
      guard++;
    end
    repeat (20) @(negedge clk_200m);
    chk("retry_data", udp_send_data, 128'h5AA50000000000000000000000000000);
    pulse();
    chk("retry_frames", DW'(frames_sent), DW'(16'd6));
    chk("retry_count", DW'(retries), DW'(16'd2));
    wait_ready(cnt);

    // Reset while offering a frame, then a stray accept while filling.
    put_byte(8'h01, 1'b0);
    put_byte(8'h02, 1'b0);
    put_byte(8'h03, 1'b1);
    s_valid = 1'b0;
    chk("rs_valid_before", DW'(udp_send_data_valid), DW'(1'b1));
    rstn = 1'b0;
    @(negedge clk_200m);
    chk("rs_valid", DW'(udp_send_data_valid), DW'(1'b0));
    chk("rs_data", udp_send_data, '0);
    chk("rs_frames", DW'(frames_sent), DW'(16'd0));
    chk("rs_retries", DW'(retries), DW'(16'd0));
    rstn = 1'b1;
    @(negedge clk_200m);
    pulse();
    chk("stray_frames", DW'(frames_sent), DW'(16'd0));
    put_byte(8'h77, 1'b0);
    s_valid = 1'b0;
    pulse();
    chk("stray_valid", DW'(udp_send_data_valid), DW'(1'b0));
    repeat (FT + 5) @(negedge clk_200m);
    chk("stray_flush_len", DW'(udp_send_data_length), DW'(16'd1));
    pulse();
    wait_ready(cnt);
    chk("end_frames", DW'(frames_sent), DW'(16'd1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
